// File: rtl/ariane_pkg.sv
// ariane_pkg: types and constants shared between the L1 TLBs, the L2 TLB,
// the page-table walker and the TLB miss scheduler.
//   tlb_update_t : refill packet (valid, page size, tag, PTE content)
//   ITLB / DTLB  : requester index constants for the miss scheduler
package ariane_pkg;

  localparam int unsigned TLB_ASID_W = 1;
  localparam int unsigned TLB_VPN_W  = 27;

  localparam int unsigned ITLB = 0;
  localparam int unsigned DTLB = 1;

  typedef struct packed {
    logic [9:0]  reserved;
    logic [43:0] ppn;
    logic [1:0]  rsw;
    logic        d;
    logic        a;
    logic        g;
    logic        u;
    logic        x;
    logic        w;
    logic        r;
    logic        v;
  } pte_t;

  typedef struct packed {
    logic                  valid;
    logic                  is_2M;
    logic                  is_1G;
    logic [TLB_VPN_W-1:0]  vpn;
    logic [TLB_ASID_W-1:0] asid;
    pte_t                  content;
  } tlb_update_t;

endpackage

// File: rtl/tlb_miss_sched_rr_arb_2.sv
// rr_arb_2: two-way round-robin arbiter used to pick between ITLB and DTLB
// misses.
//   clk_i, rst_i : clock, synchronous active-high reset
//   req          : request vector, bit0 ITLB, bit1 DTLB
//   advance      : the grant is being consumed this cycle
//   gnt          : one-hot grant (combinational)
module rr_arb_2
  import ariane_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // index of the requester served last; starts as ITLB so DTLB wins the
  // first tie
  logic last_q;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last_q ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= 1'(ITLB);
    end else if (advance && (|req)) begin
      last_q <= gnt[1];
    end
  end

endmodule

// File: rtl/tlb_miss_sched.sv
// tlb_miss_sched: serialises ITLB/DTLB misses, probes the L2 TLB and, on an
// L2 miss, requests a page-table walk; returns the refill (or a fault) to
// the requesting L1 TLB. One miss is outstanding at a time.
//   clk_i, rst_i            : clock, synchronous active-high reset
//   flush_i                 : SFENCE.VMA, aborts/discards the outstanding miss
//   miss_valid_i/vpn/asid   : per-requester miss (bit0 ITLB, bit1 DTLB)
//   miss_ready_o            : one-hot acceptance pulse
//   l2_lu_*_o, l2_hit_i,
//   l2_update_i             : L2 TLB probe and its next-cycle response
//   ptw_req_o/vpn/asid,
//   ptw_gnt_i, ptw_done_i,
//   ptw_update_i, ptw_error_i : page-table walker handshake
//   update_o, update_dest_o : refill to the L1 TLB selected one-hot
//   error_o                 : one-hot fault pulse
//   busy_o                  : a miss is in flight
module tlb_miss_sched
  import ariane_pkg::*;
#(
  parameter int unsigned ASID_WIDTH = 1,
  parameter int unsigned VPN_WIDTH  = 27
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic [1:0]                 miss_valid_i,
  input  logic [1:0][VPN_WIDTH-1:0]  miss_vpn_i,
  input  logic [1:0][ASID_WIDTH-1:0] miss_asid_i,
  output logic [1:0]                 miss_ready_o,
  output logic                       l2_lu_valid_o,
  output logic [VPN_WIDTH-1:0]       l2_lu_vpn_o,
  output logic [ASID_WIDTH-1:0]      l2_lu_asid_o,
  input  logic                       l2_hit_i,
  input  tlb_update_t                l2_update_i,
  output logic                       ptw_req_o,
  output logic [VPN_WIDTH-1:0]       ptw_vpn_o,
  output logic [ASID_WIDTH-1:0]      ptw_asid_o,
  input  logic                       ptw_gnt_i,
  input  logic                       ptw_done_i,
  input  tlb_update_t                ptw_update_i,
  input  logic                       ptw_error_i,
  output tlb_update_t                update_o,
  output logic [1:0]                 update_dest_o,
  output logic [1:0]                 error_o,
  output logic                       busy_o
);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    L2_RESP,
    WALK_REQ,
    WALK_WAIT,
    DRAIN,
    RESPOND
  } state_e;

  state_e                  state_q, state_d;
  logic                    idx_q;
  logic [VPN_WIDTH-1:0]    vpn_q;
  logic [ASID_WIDTH-1:0]   asid_q;
  logic                    is_2m_q, is_1g_q;
  pte_t                    pte_q;
  logic [1:0]              ready_q;
  logic                    lu_q, ptw_req_q, resp_q, busy_q;

  logic [1:0] gnt;
  logic       grant_en;
  logic [1:0] idx_oh;
  logic       out_en;
  logic       upd_valid;

  // tag fields of the incoming refills are replaced by the latched request
  logic unused_upd;
  assign unused_upd = ^{l2_update_i.valid, l2_update_i.vpn, l2_update_i.asid,
                        ptw_update_i.valid, ptw_update_i.vpn, ptw_update_i.asid};

  assign grant_en = (state_q == IDLE) && !flush_i && (|miss_valid_i);
  assign idx_oh   = idx_q ? 2'b10 : 2'b01;
  // outputs are held at zero while reset is asserted, whatever state
  // the registers still hold in the first reset cycle
  assign out_en   = !rst_i;

  rr_arb_2 u_arb (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req     (miss_valid_i),
    .advance (grant_en),
    .gnt     (gnt)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (grant_en) state_d = LOOKUP;
      LOOKUP:    state_d = flush_i ? IDLE : L2_RESP;
      L2_RESP: begin
        if (flush_i)       state_d = IDLE;
        else if (l2_hit_i) state_d = RESPOND;
        else               state_d = WALK_REQ;
      end
      WALK_REQ: begin
        // a grant accepted under flush still owes us a done: drain it
        if (ptw_gnt_i)    state_d = flush_i ? DRAIN : WALK_WAIT;
        else if (flush_i) state_d = IDLE;
      end
      WALK_WAIT: begin
        if (ptw_done_i)   state_d = (flush_i || ptw_error_i) ? IDLE : RESPOND;
        else if (flush_i) state_d = DRAIN;
      end
      DRAIN:     if (ptw_done_i) state_d = IDLE;
      RESPOND:   state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      idx_q     <= 1'b0;
      vpn_q     <= '0;
      asid_q    <= '0;
      is_2m_q   <= 1'b0;
      is_1g_q   <= 1'b0;
      pte_q     <= '0;
      ready_q   <= '0;
      lu_q      <= 1'b0;
      ptw_req_q <= 1'b0;
      resp_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ready_q   <= grant_en ? gnt : 2'b00;
      lu_q      <= (state_d == LOOKUP);
      ptw_req_q <= (state_d == WALK_REQ);
      resp_q    <= (state_d == RESPOND);
      busy_q    <= (state_d != IDLE);
      if (grant_en) begin
        idx_q  <= gnt[1];
        vpn_q  <= miss_vpn_i[gnt[1]];
        asid_q <= miss_asid_i[gnt[1]];
      end
      if (state_q == L2_RESP && state_d == RESPOND) begin
        is_2m_q <= l2_update_i.is_2M;
        is_1g_q <= l2_update_i.is_1G;
        pte_q   <= l2_update_i.content;
      end else if (state_q == WALK_WAIT && state_d == RESPOND) begin
        is_2m_q <= ptw_update_i.is_2M;
        is_1g_q <= ptw_update_i.is_1G;
        pte_q   <= ptw_update_i.content;
      end
    end
  end

  assign miss_ready_o  = out_en ? ready_q : 2'b00;
  assign l2_lu_valid_o = out_en && lu_q;
  assign l2_lu_vpn_o   = l2_lu_valid_o ? vpn_q : '0;
  assign l2_lu_asid_o  = l2_lu_valid_o ? asid_q : '0;
  assign ptw_req_o     = out_en && ptw_req_q;
  assign ptw_vpn_o     = ptw_req_o ? vpn_q : '0;
  assign ptw_asid_o    = ptw_req_o ? asid_q : '0;
  assign busy_o        = out_en && busy_q;

  // a flush arriving in RESPOND kills the refill at the last moment
  assign upd_valid     = out_en && resp_q && !flush_i;
  assign update_dest_o = upd_valid ? idx_oh : 2'b00;

  always_comb begin
    update_o = '0;
    if (upd_valid) begin
      update_o.valid   = 1'b1;
      update_o.is_2M   = is_2m_q;
      update_o.is_1G   = is_1g_q;
      update_o.vpn     = TLB_VPN_W'(vpn_q);
      update_o.asid    = TLB_ASID_W'(asid_q);
      update_o.content = pte_q;
    end
  end

  // faults are reported in the done cycle itself
  assign error_o = (out_en && state_q == WALK_WAIT && ptw_done_i && ptw_error_i && !flush_i)
                   ? idx_oh : 2'b00;

endmodule
